rsa_mont_const: RTL

- Computes the Montgomery constant R^2 mod P, where R = 2^WIDTH, i.e. const_out = 2^(2*WIDTH) mod P.
- Sits directly upstream of the RSA exponentiation unit and drives its Const operand, so the host no longer precomputes Const and writes it over SPI.
- Started by the enable controller, or by an SPI command, once P is loaded.
- Uses a serial shift-and-conditional-subtract loop: one modular doubling per clock.

---
 rtl/rsa_mont_const_if.sv | 26 ++
 rtl/rsa_mont_const.sv | 119 +++++++++++
 2 files changed

// File: rtl/rsa_mont_const_if.sv
// Control/result bundle between the Montgomery constant generator and its driver.
interface rsa_mont_const_if #(
   parameter int unsigned WIDTH = 8
);
   logic             ena;
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] p;
   logic             busy;
   logic             done;
   logic             valid;
   logic             err;
   logic [WIDTH-1:0] const_out;

   // Requester side: enable controller / SPI command decoder
   modport master (
      output ena, start, abort, p,
      input  busy, done, valid, err, const_out
   );

   // Constant generator side
   modport slave (
      input  ena, start, abort, p,
      output busy, done, valid, err, const_out
   );
endinterface

// File: rtl/rsa_mont_const.sv
// Serial generator of the Montgomery constant R^2 mod P (R = 2^WIDTH),
// one modular doubling per enabled clock starting from r = 1.
module rsa_mont_const #(
   parameter int unsigned WIDTH = 8
) (
   input logic               clk,
   input logic               rst,
   rsa_mont_const_if.slave   bus
);
   localparam int unsigned CW    = $clog2(2 * WIDTH) + 1;
   localparam int unsigned ITERS = 2 * WIDTH;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_CALC = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] const_q, const_d;

   logic [WIDTH:0]   dbl;
   logic [WIDTH:0]   r_next;
   logic             p_bad;

   // Modular doubling; r < p_q keeps a single conditional subtract sufficient
   assign dbl    = {r_q, 1'b0};
   assign r_next = (dbl >= {1'b0, p_q}) ? (dbl - {1'b0, p_q}) : dbl;
   assign p_bad  = ~bus.p[0] | (bus.p < WIDTH'(3));

   // Next-state and next-output decode
   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      valid_d = valid_q;
      err_d   = err_q;
      const_d = const_q;

      if (!bus.ena) begin
         done_d = done_q;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start && !bus.abort) begin
                  valid_d = 1'b0;
                  if (p_bad) begin
                     err_d  = 1'b1;
                     done_d = 1'b1;
                  end else begin
                     p_d     = bus.p;
                     r_d     = WIDTH'(1);
                     cnt_d   = '0;
                     err_d   = 1'b0;
                     busy_d  = 1'b1;
                     state_d = S_CALC;
                  end
               end
            end
            S_CALC: begin
               if (bus.abort) begin
                  busy_d  = 1'b0;
                  valid_d = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  r_d   = r_next[WIDTH-1:0];
                  cnt_d = cnt_q + CW'(1);
                  if (cnt_q == CW'(ITERS - 1)) begin
                     const_d = r_next[WIDTH-1:0];
                     valid_d = 1'b1;
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = S_IDLE;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         p_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         const_q <= '0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         const_q <= const_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.valid     = valid_q;
   assign bus.err       = err_q;
   assign bus.const_out = const_q;
endmodule
